// File: rtl/serial_adder_ctrl.sv
`timescale 1ns/1ps
// Multi-precision add/subtract sequencer: one 4-bit ripple adder,
// one slice per clock LSB first, carry registered between slices.

module RippleCarryAdder4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[4];

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             busy
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0] sl_a;
  logic [3:0] sl_b;
  logic [3:0] sl_s;
  logic       sl_c;
  logic       accept;

  assign sl_a = a_q[{idx_q, 2'b00} +: 4];
  assign sl_b = b_q[{idx_q, 2'b00} +: 4];

  RippleCarryAdder4bit u_add (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_s),
    .cout (sl_c)
  );

  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign sum       = sum_q;
  assign c_out     = cout_q;
  assign overflow  = ovf_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : c_in;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = sl_s;
        carry_d = sl_c;
        if (idx_q == LAST) begin
          // sl_s[3] is the final result MSB
          cout_d  = sl_c;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                 && (sl_s[3] != a_q[WIDTH-1]);
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for serial_adder_ctrl: directed cases, backpressure,
// mid-run reset and a randomized regression against an arithmetic model.

module tb_serial_adder_ctrl;

  localparam int W  = 16;
  localparam int NS = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         c_in = 1'b0;
  logic         sub = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic         c_out;
  logic         overflow;
  logic         busy;
  logic [W-1:0] sum;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   rdy_rand = 1'b0;
  bit   prev_v = 1'b0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic ci, input logic s);
    exp_t   e;
    int     r;
    longint u;
    if (s) begin
      r    = int'($signed(x)) - int'($signed(y));
      e.s  = x - y;
      e.co = (x >= y);
    end else begin
      r    = int'($signed(x)) + int'($signed(y)) + int'(ci);
      u    = longint'(x) + longint'(y) + longint'(ci);
      e.s  = W'(u);
      e.co = (u >= (longint'(1) << W));
    end
    e.ov  = (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
    e.acc = 0;
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
        else chk("latency", cyc - q[0].acc, NS);
      end
      if (out_valid && out_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("result", {sum, c_out, overflow}, {e.s, e.co, e.ov});
      end
      prev_v = out_valid;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic do_op_exp(input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tc, input logic ts, input exp_t e);
    int   n;
    exp_t x;
    n = 0;
    x = e;
    @(posedge clk);
    #1;
    a = ta;
    b = tb;
    c_in = tc;
    sub = ts;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk("in_ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    if (in_ready) begin
      x.acc = cyc + 1;
      q.push_back(x);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc, input logic ts);
    do_op_exp(ta, tb, tc, ts, model(ta, tb, tc, ts));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 32'd0);
  endtask

  initial begin : main
    exp_t         dropped;
    logic [W-1:0] s0;
    logic         c0;
    int           n;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sum", sum, 32'd0);
    chk("rst_flags", {out_valid, c_out, overflow, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 32'd1);

    out_ready = 1'b1;
    do_op_exp(16'hFFFF, 16'h0001, 1'b0, 1'b0,
              '{s: 16'h0000, co: 1'b1, ov: 1'b0, acc: 0});
    do_op_exp(16'h7FFF, 16'h0001, 1'b0, 1'b0,
              '{s: 16'h8000, co: 1'b0, ov: 1'b1, acc: 0});
    do_op_exp(16'h1234, 16'h4321, 1'b1, 1'b0,
              '{s: 16'h5556, co: 1'b0, ov: 1'b0, acc: 0});
    do_op_exp(16'h0005, 16'h0007, 1'b1, 1'b1,
              '{s: 16'hFFFE, co: 1'b0, ov: 1'b0, acc: 0});
    drain();

    out_ready = 1'b0;
    do_op(16'hBEEF, 16'h1357, 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", out_valid, 32'd1);
    s0 = sum;
    c0 = c_out;
    repeat (10) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom_range(0, 1));
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
      chk("bp_hold", {out_valid, in_ready, busy, c_out, sum},
          {1'b1, 1'b0, 1'b1, c0, s0});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle", {out_valid, in_ready, busy}, 32'b010);
    drain();

    do_op(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {out_valid, busy, sum}, 32'd0);
    if (q.size() != 0) dropped = q.pop_back();
    @(negedge clk);
    rst_n = 1'b1;
    do_op_exp(16'h0F0F, 16'h00F1, 1'b0, 1'b0,
              '{s: 16'h1000, co: 1'b0, ov: 1'b0, acc: 0});
    drain();

    rdy_rand = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_op(W'($urandom), W'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();
    rdy_rand = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
